log_event_mux: RTL



---
 rtl/log_hw_pkg.sv | 44 ++++
 rtl/log_event_mux_fifo.sv | 52 +++++
 rtl/log_event_mux.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/log_hw_pkg.sv
// log_hw_pkg: severity/verbosity encodings and record layout shared
// by the hardware event logger and its host-side decode tooling.
package log_hw_pkg;

    localparam int LOG_TS_W   = 32;
    localparam int LOG_DATA_W = 32;
    localparam int LOG_CNT_W  = 16;

    typedef enum logic [1:0] {
        SEV_INFO  = 2'd0,
        SEV_WARN  = 2'd1,
        SEV_ERROR = 2'd2,
        SEV_FATAL = 2'd3
    } log_sev_t;

    typedef enum logic [2:0] {
        LVL_NONE   = 3'd0,
        LVL_LOW    = 3'd1,
        LVL_MEDIUM = 3'd2,
        LVL_HIGH   = 3'd3,
        LVL_DEBUG  = 3'd4
    } log_level_t;

    typedef logic [LOG_TS_W-1:0]   log_ts_t;
    typedef logic [LOG_DATA_W-1:0] log_data_t;

    typedef struct packed {
        log_sev_t  sev;
        log_ts_t   ts;
        log_data_t data;
    } log_entry_t;

    // ERROR and FATAL always get through an enabled channel
    function automatic logic log_pass(
        input logic       en,
        input logic [1:0] sev,
        input logic [2:0] lvl,
        input logic [2:0] thr
    );
        return en && ((sev >= SEV_ERROR) ||
                      ((lvl != LVL_NONE) && (lvl <= thr)));
    endfunction

endpackage

// File: rtl/log_event_mux_fifo.sv
// log_fifo: single-clock synchronous FIFO, power-of-two depth,
// extra pointer bit distinguishes full from empty.
module log_fifo
    import log_hw_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_wr_en;
    logic             w_rd_en;

    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_wr_en)
                r_wr <= r_wr + (AW+1)'(1);
            if (w_rd_en)
                r_rd <= r_rd + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr[AW-1:0]] <= i_din;
    end

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                     (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_head  = r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/log_event_mux.sv
// log_event_mux: filters, timestamps and buffers per-channel log events,
// then merges them (FATAL first, else round-robin) into one stream.
module log_event_mux
    import log_hw_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int TS_WIDTH     = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int DROP_ON_FULL = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              ev_valid,
    output logic [NUM_CH-1:0]              ev_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ev_data,
    input  logic [NUM_CH*2-1:0]            ev_sev,
    input  logic [NUM_CH*3-1:0]            ev_level,
    input  logic [NUM_CH-1:0]              cfg_enable,
    input  logic [2:0]                     cfg_level,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
    output logic [1:0]                     out_sev,
    output logic [TS_WIDTH-1:0]            out_ts,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [NUM_CH*LOG_CNT_W-1:0]    drop_cnt,
    output logic                           fatal_seen
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int EW   = 2 + TS_WIDTH + DATA_WIDTH;

    typedef struct packed {
        log_sev_t              sev;
        logic [TS_WIDTH-1:0]   ts;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [TS_WIDTH-1:0] r_ts;
    logic                r_out_valid;
    entry_t              r_out;
    logic [CH_W-1:0]     r_out_ch;
    logic [CH_W-1:0]     r_last;
    logic                r_fatal;

    logic [NUM_CH-1:0]   w_full;
    logic [NUM_CH-1:0]   w_empty;
    logic [NUM_CH-1:0]   w_push;
    logic [NUM_CH-1:0]   w_drop;
    logic [NUM_CH-1:0]   w_pop;
    logic [NUM_CH-1:0]   w_is_fatal;
    logic [NUM_CH-1:0]   w_head_fatal;
    entry_t              w_din  [NUM_CH];
    entry_t              w_head [NUM_CH];
    logic                w_load;
    logic                w_gnt_vld;
    logic [CH_W-1:0]     w_gnt;

    assign ev_ready = (DROP_ON_FULL != 0) ? {NUM_CH{1'b1}} : ~w_full;
    assign w_load   = !r_out_valid || out_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic                 w_ok;
        logic [LOG_CNT_W-1:0] r_cnt;

        assign w_ok = ev_valid[g] && ev_ready[g] &&
                      log_pass(cfg_enable[g], ev_sev[g*2 +: 2],
                               ev_level[g*3 +: 3], cfg_level);

        assign w_push[g]       = w_ok && !w_full[g];
        assign w_drop[g]       = w_ok && w_full[g];
        assign w_is_fatal[g]   = (ev_sev[g*2 +: 2] == SEV_FATAL);
        assign w_din[g]        = {ev_sev[g*2 +: 2], r_ts,
                                  ev_data[g*DATA_WIDTH +: DATA_WIDTH]};
        assign w_head_fatal[g] = !w_empty[g] &&
                                 (w_head[g].sev == SEV_FATAL);
        assign w_pop[g]        = w_load && w_gnt_vld &&
                                 (w_gnt == CH_W'(g));

        log_fifo #(
            .WIDTH (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_din   (w_din[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_head  (w_head[g])
        );

        always_ff @(posedge clk) begin
            if (!rst_n)
                r_cnt <= '0;
            else if (w_drop[g] && (r_cnt != {LOG_CNT_W{1'b1}}))
                r_cnt <= r_cnt + LOG_CNT_W'(1);
        end

        assign drop_cnt[g*LOG_CNT_W +: LOG_CNT_W] = r_cnt;
    end

    // loops run backwards so the highest-priority hit is written last
    always_comb begin
        int idx;
        idx       = 0;
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_head_fatal[i]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = CH_W'(i);
            end
        end
        if (!w_gnt_vld) begin
            for (int k = NUM_CH; k >= 1; k--) begin
                idx = int'(r_last) + k;
                if (idx >= NUM_CH)
                    idx = idx - NUM_CH;
                if (!w_empty[idx]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = CH_W'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ts        <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_ch    <= '0;
            r_last      <= CH_W'(NUM_CH - 1);
            r_fatal     <= 1'b0;
        end else begin
            r_ts    <= r_ts + TS_WIDTH'(1);
            r_fatal <= r_fatal || (|(w_push & w_is_fatal));
            if (w_load) begin
                r_out_valid <= w_gnt_vld;
                if (w_gnt_vld) begin
                    r_out    <= w_head[w_gnt];
                    r_out_ch <= w_gnt;
                    r_last   <= w_gnt;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_ch     = r_out_ch;
    assign out_sev    = r_out.sev;
    assign out_ts     = r_out.ts;
    assign out_data   = r_out.data;
    assign fatal_seen = r_fatal;

endmodule
